// File: rtl/de1_cl_inputs_scanner_pkg.sv
// Shared types for the DE1 CL input scanner: scan FSM states and rotary position type.
package de1_cl_inputs_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      LOW,
      HIGH,
      DONE,
      GAP
   } t_scan_state;

   typedef logic [7:0] t_rotary_count;

endpackage

// File: rtl/de1_cl_inputs_scanner_if.sv
// Published scan result bus: latest switch/button word with valid and changed strobes.
interface de1_cl_inputs_scanner_if #(
   parameter int unsigned SR_BITS = 16
);
   logic [SR_BITS-1:0] inputs_state;
   logic               inputs_valid;
   logic               inputs_changed;

   modport master (output inputs_state, output inputs_valid, output inputs_changed);
   modport slave  (input  inputs_state, input  inputs_valid, input  inputs_changed);
endinterface

// File: rtl/de1_cl_rotary_counter.sv
// One rotary encoder: pin synchronisers, transition rising-edge detect, wrapping up/down count.
module de1_cl_rotary_counter
   import de1_cl_inputs_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          direction_pin,
   input  logic          transition_pin,
   output t_rotary_count count
);

   logic [1:0] dir_sync;
   logic [1:0] tr_sync;
   logic       tr_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         dir_sync <= '0;
         tr_sync  <= '0;
         tr_prev  <= 1'b0;
         count    <= '0;
      end else begin
         dir_sync <= {dir_sync[0], direction_pin};
         tr_sync  <= {tr_sync[0], transition_pin};
         tr_prev  <= tr_sync[1];
         // 8-bit arithmetic wraps naturally: 255+1=0, 0-1=255
         if (tr_sync[1] && !tr_prev)
            count <= dir_sync[1] ? count + 1'b1 : count - 1'b1;
      end
   end

endmodule

// File: rtl/de1_cl_inputs_scanner.sv
// Scans the DE1 CL 74HC165-style input chain into a stable word and tracks both rotary encoders.
module de1_cl_inputs_scanner
   import de1_cl_inputs_pkg::*;
#(
   parameter int unsigned SR_BITS  = 16,
   parameter int unsigned CLK_DIV  = 25,
   parameter int unsigned SCAN_GAP = 50000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      scan_enable,
   input  logic                      sr_data,
   input  logic                      left_direction_pin,
   input  logic                      left_transition_pin,
   input  logic                      right_direction_pin,
   input  logic                      right_transition_pin,
   output logic                      sr_clock,
   output logic                      sr_shift,
   de1_cl_inputs_scanner_if.master   result,
   output t_rotary_count             left_count,
   output t_rotary_count             right_count
);

   localparam int unsigned CNT_MAX = (SCAN_GAP > CLK_DIV) ? SCAN_GAP : CLK_DIV;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned IDX_W   = $clog2(SR_BITS);

   t_scan_state        state, state_next;
   logic [CNT_W-1:0]   phase;
   logic [IDX_W-1:0]   bit_idx;
   logic [SR_BITS-1:0] acc;
   logic [1:0]         data_sync;
   logic               phase_last, gap_last, idx_last;
   logic               sample, publish;

   assign phase_last = (phase == CNT_W'(CLK_DIV - 1));
   assign gap_last   = (phase == CNT_W'(SCAN_GAP - 1));
   assign idx_last   = (bit_idx == IDX_W'(SR_BITS - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // scan_enable is only consulted in IDLE and at the end of GAP, so a running scan always completes
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (scan_enable) state_next = LOAD;
         LOAD:    if (phase_last)  state_next = LOW;
         LOW:     if (phase_last)  state_next = idx_last ? DONE : HIGH;
         HIGH:    if (phase_last)  state_next = LOW;
         DONE:                     state_next = GAP;
         GAP:     if (gap_last)    state_next = scan_enable ? LOAD : IDLE;
         default:                  state_next = IDLE;
      endcase
   end

   always_comb begin
      sr_shift = (state != LOAD);
      sr_clock = (state == HIGH);
      sample   = (state == LOW) && phase_last;
      publish  = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_sync <= '0;
         phase     <= '0;
         bit_idx   <= '0;
         acc       <= '0;
      end else begin
         data_sync <= {data_sync[0], sr_data};
         if (state_next != state || state == IDLE)
            phase <= '0;
         else
            phase <= phase + 1'b1;
         if (state == LOAD)
            bit_idx <= '0;
         else if (state == HIGH && phase_last)
            bit_idx <= bit_idx + 1'b1;
         // first bit out of the chain ends up in the MSB
         if (sample)
            acc <= {acc[SR_BITS-2:0], data_sync[1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result.inputs_state   <= '0;
         result.inputs_valid   <= 1'b0;
         result.inputs_changed <= 1'b0;
      end else begin
         result.inputs_valid   <= publish;
         result.inputs_changed <= publish && (acc != result.inputs_state);
         if (publish)
            result.inputs_state <= acc;
      end
   end

   de1_cl_rotary_counter u_left (
      .clk            (clk),
      .reset          (reset),
      .direction_pin  (left_direction_pin),
      .transition_pin (left_transition_pin),
      .count          (left_count)
   );

   de1_cl_rotary_counter u_right (
      .clk            (clk),
      .reset          (reset),
      .direction_pin  (right_direction_pin),
      .transition_pin (right_transition_pin),
      .count          (right_count)
   );

endmodule

// File: tb/tb_de1_cl_inputs_scanner.sv
// Bench for de1_cl_inputs_scanner: modelled 74HC165 chain, scan result scoreboard, rotary checks.
module tb_de1_cl_inputs_scanner;
   import de1_cl_inputs_pkg::*;

   typedef struct {
      logic [15:0] state;
      logic        changed;
   } t_exp;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic scan_enable = 1'b0;
   logic sr_data;
   logic left_direction_pin = 1'b0, left_transition_pin = 1'b0;
   logic right_direction_pin = 1'b0, right_transition_pin = 1'b0;
   logic sr_clock, sr_shift;
   t_rotary_count left_count, right_count;

   de1_cl_inputs_scanner_if #(.SR_BITS(16)) res_if ();

   de1_cl_inputs_scanner #(
      .SR_BITS  (16),
      .CLK_DIV  (4),
      .SCAN_GAP (20)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .scan_enable          (scan_enable),
      .sr_data              (sr_data),
      .left_direction_pin   (left_direction_pin),
      .left_transition_pin  (left_transition_pin),
      .right_direction_pin  (right_direction_pin),
      .right_transition_pin (right_transition_pin),
      .sr_clock             (sr_clock),
      .sr_shift             (sr_shift),
      .result               (res_if),
      .left_count           (left_count),
      .right_count          (right_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // 74HC165 chain model: parallel load while sr_shift=0, shift on sr_clock rising edge
   logic [15:0] pattern = 16'hA5C3;
   logic [15:0] chain = '0;
   logic        clk_d = 1'b0;
   assign sr_data = chain[15];
   always @(posedge clk) begin
      clk_d <= sr_clock;
      if (!sr_shift)
         chain <= pattern;
      else if (sr_clock && !clk_d)
         chain <= {chain[14:0], 1'b0};
   end

   // Scoreboard plus per-scan pin activity monitor
   t_exp sb[$];
   int   load_cyc = -1000, last_valid_cyc = 0, valid_cnt = 0;
   int   shift_low = 0, rises = 0, high_cyc = 0;
   logic prev_shift = 1'b1, prev_clk = 1'b0;

   always @(negedge clk) begin
      t_exp e;
      if (reset) begin
         shift_low = 0; rises = 0; high_cyc = 0;
         prev_shift = 1'b1; prev_clk = 1'b0;
      end else begin
         if (prev_shift && !sr_shift) begin
            load_cyc = cyc; shift_low = 0; rises = 0; high_cyc = 0;
         end
         if (!sr_shift) shift_low++;
         if (sr_clock && !prev_clk) rises++;
         if (sr_clock) high_cyc++;
         prev_shift = sr_shift;
         prev_clk   = sr_clock;
         if (!res_if.inputs_valid && res_if.inputs_changed)
            check("changed_without_valid", 1, 0);
         if (res_if.inputs_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            check("valid_latency", cyc - load_cyc, 129);
            check("load_cycles", shift_low, 4);
            check("clock_pulses", rises, 15);
            check("clock_high_cycles", high_cyc, 60);
            if (sb.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               check("inputs_state", res_if.inputs_state, e.state);
               check("inputs_changed", res_if.inputs_changed, e.changed);
            end
         end
      end
   end

   task automatic wait_valid(input int budget);
      int start = valid_cnt;
      for (int i = 0; i < budget && valid_cnt == start; i++) @(negedge clk);
      check("valid_arrived", valid_cnt != start, 1);
   endtask

   task automatic wait_new_scan_sample(input int n);
      int prev_load = load_cyc;
      for (int i = 0; i < 100 && load_cyc == prev_load; i++) @(negedge clk);
      for (int i = 0; i < 300 && rises < n; i++) @(negedge clk);
      check("scan_reached_sample", rises, n);
   endtask

   t_rotary_count exp_left = '0, exp_right = '0;

   task automatic rot_pulse(input logic do_l, input logic do_r, input logic dir);
      t_rotary_count l0 = left_count, r0 = right_count;
      if (do_l) begin left_direction_pin = dir; exp_left = dir ? exp_left + 1'b1 : exp_left - 1'b1; end
      if (do_r) begin right_direction_pin = dir; exp_right = dir ? exp_right + 1'b1 : exp_right - 1'b1; end
      repeat (3) @(negedge clk);
      if (do_l) left_transition_pin = 1'b1;
      if (do_r) right_transition_pin = 1'b1;
      for (int i = 0; i < 10 && left_count == l0 && right_count == r0; i++) @(negedge clk);
      check("left_count", left_count, exp_left);
      check("right_count", right_count, exp_right);
      left_transition_pin = 1'b0;
      right_transition_pin = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int v1, rel_cyc, vc;
      repeat (3) @(negedge clk);
      check("rst_sr_shift", sr_shift, 1);
      check("rst_sr_clock", sr_clock, 0);
      check("rst_inputs_state", res_if.inputs_state, 0);
      check("rst_inputs_valid", res_if.inputs_valid, 0);
      check("rst_left_count", left_count, 0);
      check("rst_right_count", right_count, 0);

      // First scan after reset: nonzero word must flag changed
      scan_enable = 1'b1;
      sb.push_back('{16'hA5C3, 1'b1});
      reset = 1'b0;
      wait_valid(300);
      v1 = last_valid_cyc;

      // Same word again: back-to-back period is gap + scan + done
      sb.push_back('{16'hA5C3, 1'b0});
      wait_valid(300);
      check("scan_period", last_valid_cyc - v1, 149);

      pattern = 16'hA5C2;
      sb.push_back('{16'hA5C2, 1'b1});
      wait_valid(300);

      // Dropping enable mid-scan lets the scan finish, then the FSM parks in IDLE
      sb.push_back('{16'hA5C2, 1'b0});
      wait_new_scan_sample(5);
      scan_enable = 1'b0;
      wait_valid(300);
      vc = valid_cnt;
      repeat (200) @(negedge clk);
      check("idle_no_valid", valid_cnt, vc);
      check("idle_sr_shift", sr_shift, 1);
      check("idle_sr_clock", sr_clock, 0);

      // Reset mid-scan discards the partial word
      scan_enable = 1'b1;
      wait_new_scan_sample(10);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_sr_clock", sr_clock, 0);
      check("midrst_sr_shift", sr_shift, 1);
      check("midrst_inputs_state", res_if.inputs_state, 0);
      check("midrst_inputs_valid", res_if.inputs_valid, 0);
      @(negedge clk);
      sb.push_back('{16'hA5C2, 1'b1});
      reset = 1'b0;
      rel_cyc = cyc;
      wait_valid(300);
      check("restart_delay", load_cyc - rel_cyc, 1);
      scan_enable = 1'b0;
      repeat (40) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);

      // Rotary encoders
      reset = 1'b1;
      exp_left = '0;
      exp_right = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) rot_pulse(1'b1, 1'b0, 1'b0);
      check("left_after_3_down", left_count, 253);
      repeat (3) rot_pulse(1'b1, 1'b0, 1'b1);
      rot_pulse(1'b1, 1'b1, 1'b1);
      check("left_after_4_up", left_count, 1);
      check("right_after_1_up", right_count, 1);

      left_direction_pin = 1'b1;
      repeat (3) @(negedge clk);
      left_transition_pin = 1'b1;
      repeat (100) @(negedge clk);
      check("held_high_one_count", left_count, 2);
      for (int i = 0; i < 6; i++) begin
         left_direction_pin = ~left_direction_pin;
         repeat (2) @(negedge clk);
      end
      left_transition_pin = 1'b0;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         left_direction_pin = ~left_direction_pin;
         repeat (2) @(negedge clk);
      end
      repeat (5) @(negedge clk);
      check("dir_glitch_no_count", left_count, 2);
      check("right_untouched", right_count, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
